mpu_ctlif_mc: RTL

MPU_CTLIF_MC -- requirements
Module: mpu_ctlif_mc

---
 rtl/mpu_ctlif_mc_pkg.sv | 45 ++++
 rtl/mpu_ctlif_mc_ch.sv | 122 ++++++++++++
 rtl/mpu_ctlif_mc.sv | 88 ++++++++
 3 files changed

// File: rtl/mpu_ctlif_mc_pkg.sv
// Shared definitions for the MPU control interface: channel state
// encodings, event bit positions, CSR offsets and the per-channel CSR
// request/response structs.
package mpu_ctlif_mc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RESET = 3'd1,
    ST_RUN   = 3'd2,
    ST_WAIT  = 3'd3
  } ch_state_e;

  // Event bit positions inside STAT[3:0] and CTRL mask[3:0]
  localparam int EV_END = 0;
  localparam int EV_ERR = 1;
  localparam int EV_USR = 2;
  localparam int EV_TMO = 3;

  // Register offsets inside a 16-word channel window
  localparam logic [3:0] OFS_STAT = 4'd0;
  localparam logic [3:0] OFS_CTRL = 4'd1;
  localparam logic [3:0] OFS_DLO  = 4'd2;
  localparam logic [3:0] OFS_DHI  = 4'd3;
  localparam logic [3:0] OFS_TMO  = 4'd4;

  // Bank-wide pending-interrupt summary (word offset)
  localparam logic [9:0] OFS_IRQ_PEND = 10'h3FC;

  // Decoded write strobes for one channel
  typedef struct packed {
    logic stat;
    logic ctrl;
    logic tmo;
  } ch_wr_t;

  // Read-back views of one channel's registers
  typedef struct packed {
    logic [31:0] stat;
    logic [31:0] ctrl;
    logic [31:0] dlo;
    logic [31:0] dhi;
    logic [31:0] tmo;
  } ch_rd_t;

endpackage

// File: rtl/mpu_ctlif_mc_ch.sv
// One MPU channel: run-control FSM, event/mask/start registers, latched
// user data, TIMEOUT register and watchdog.
module mpu_ctlif_ch
  import mpu_ctlif_mc_pkg::*;
#(
  parameter int TMO_W = 32
) (
  input  logic        gclk,
  input  logic        grst_n,
  input  ch_wr_t      wr,
  input  logic [31:0] wdata,
  input  logic        user_irq,
  input  logic [63:0] user_data,
  input  logic        error,
  output logic        mpu_en,
  output logic        mpu_rst,
  output logic        irq,
  output ch_rd_t      rd
);

  ch_state_e        state, state_nx;
  logic             start, start_nx;
  logic [3:0]       ev, ev_nx;
  logic [3:0]       mask;
  logic [63:0]      data, data_nx;
  logic [TMO_W-1:0] tmo, wdog, wdog_nx, wdog_inc;
  logic             unused_wdata;

  // Upper write-data bits only matter for wide TIMEOUT registers
  assign unused_wdata = ^wdata;

  // Saturating increment: the watchdog never wraps
  assign wdog_inc = (wdog == '1) ? wdog : wdog + TMO_W'(1);

  // Next-state logic; CSR writes are applied first so hardware events override them
  always_comb begin
    state_nx = state;
    start_nx = start;
    ev_nx    = ev;
    data_nx  = data;
    wdog_nx  = wdog;
    if (wr.ctrl) start_nx = wdata[0];
    if (wr.stat && (state == ST_IDLE || state == ST_WAIT)) ev_nx = ev & ~wdata[3:0];
    case (state)
      ST_IDLE: begin
        if (start) state_nx = ST_RESET;
      end
      ST_RESET: begin
        state_nx = ST_RUN;
        wdog_nx  = '0;
      end
      ST_RUN: begin
        wdog_nx = wdog_inc;
        if (!start) begin
          state_nx = ST_IDLE;
        end else if (error) begin
          state_nx      = ST_IDLE;
          ev_nx[EV_ERR] = 1'b1;
          start_nx      = 1'b0;
        end else if (tmo != '0 && wdog_inc == tmo) begin
          // the current RUN cycle is counted, so the channel runs exactly TIMEOUT cycles
          state_nx      = ST_IDLE;
          ev_nx[EV_TMO] = 1'b1;
          start_nx      = 1'b0;
        end else if (user_irq) begin
          if (user_data == '0) begin
            state_nx      = ST_IDLE;
            ev_nx[EV_END] = 1'b1;
            start_nx      = 1'b0;
          end else begin
            state_nx      = ST_WAIT;
            ev_nx[EV_USR] = 1'b1;
            data_nx       = user_data;
          end
        end
      end
      ST_WAIT: begin
        if (!ev[EV_USR]) begin
          state_nx = ST_RUN;
          data_nx  = '0;
        end else if (!start) begin
          state_nx = ST_IDLE;
          data_nx  = '0;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Channel state; mask and TIMEOUT are only writable while idle
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      state <= ST_IDLE;
      start <= 1'b0;
      ev    <= '0;
      data  <= '0;
      wdog  <= '0;
      mask  <= '0;
      tmo   <= '0;
    end else begin
      state <= state_nx;
      start <= start_nx;
      ev    <= ev_nx;
      data  <= data_nx;
      wdog  <= wdog_nx;
      if (wr.ctrl && state == ST_IDLE) mask <= wdata[4:1];
      if (wr.tmo  && state == ST_IDLE) tmo  <= wdata[TMO_W-1:0];
    end
  end

  // Outputs decode straight from the state register, so reset drops them at once
  assign mpu_en  = (state == ST_RUN);
  assign mpu_rst = (state == ST_RESET);
  assign irq     = |(ev & mask);

  assign rd.stat = {25'b0, state, ev};
  assign rd.ctrl = {27'b0, mask, start};
  assign rd.dlo  = data[31:0];
  assign rd.dhi  = data[63:32];
  assign rd.tmo  = 32'(tmo);

endmodule

// File: rtl/mpu_ctlif_mc.sv
// MPU control interface top: CSR bank decode, registered read mux and
// interrupt OR over NCH independent channels.
module mpu_ctlif_mc
  import mpu_ctlif_mc_pkg::*;
#(
  parameter logic [3:0] csr_addr = 4'h0,
  parameter int         NCH      = 4,
  parameter int         TMO_W    = 32
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [13:0]       csr_a,
  input  logic              csr_we,
  input  logic [31:0]       csr_di,
  output logic [31:0]       csr_do,
  output logic [NCH-1:0]    mpu_en,
  output logic [NCH-1:0]    mpu_rst,
  input  logic [NCH-1:0]    user_irq,
  input  logic [NCH*64-1:0] user_data,
  input  logic [NCH-1:0]    error,
  output logic              irq
);

  logic                 bank_sel;
  logic [9:0]           ofs;
  logic [5:0]           ch_idx;
  logic [3:0]           reg_sel;
  logic [NCH-1:0]       ch_irq;
  ch_rd_t [NCH-1:0]     ch_rd;
  logic [31:0]          rd_nx;

  assign bank_sel = (csr_a[13:10] == csr_addr);
  assign ofs      = csr_a[9:0];
  assign ch_idx   = csr_a[9:4];
  assign reg_sel  = csr_a[3:0];

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    ch_wr_t wr;
    logic   hit;
    assign hit     = csr_we && bank_sel && (ch_idx == 6'(i));
    assign wr.stat = hit && (reg_sel == OFS_STAT);
    assign wr.ctrl = hit && (reg_sel == OFS_CTRL);
    assign wr.tmo  = hit && (reg_sel == OFS_TMO);

    mpu_ctlif_ch #(.TMO_W(TMO_W)) u_ch (
      .gclk      (sys_clk),
      .grst_n    (sys_rst_n),
      .wr        (wr),
      .wdata     (csr_di),
      .user_irq  (user_irq[i]),
      .user_data (user_data[64*i +: 64]),
      .error     (error[i]),
      .mpu_en    (mpu_en[i]),
      .mpu_rst   (mpu_rst[i]),
      .irq       (ch_irq[i]),
      .rd        (ch_rd[i])
    );
  end

  // Read mux: unselected bank, unmapped offsets and absent channels read 0
  always_comb begin
    rd_nx = '0;
    if (bank_sel) begin
      if (ofs == OFS_IRQ_PEND) rd_nx = 32'(ch_irq);
      for (int i = 0; i < NCH; i++) begin
        if (ch_idx == 6'(i)) begin
          case (reg_sel)
            OFS_STAT: rd_nx = ch_rd[i].stat;
            OFS_CTRL: rd_nx = ch_rd[i].ctrl;
            OFS_DLO:  rd_nx = ch_rd[i].dlo;
            OFS_DHI:  rd_nx = ch_rd[i].dhi;
            OFS_TMO:  rd_nx = ch_rd[i].tmo;
            default:  rd_nx = '0;
          endcase
        end
      end
    end
  end

  // Registered read data, one cycle after the address
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) csr_do <= '0;
    else            csr_do <= rd_nx;
  end

  assign irq = |ch_irq;

endmodule
